// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: optional data-memory load/store, then a
// registered register-file write with a matching forwarding tap.
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_wb,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              write_en,
    output logic [REG_AW-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              illegal_op,
    output logic [15:0]       retired_count
);

    localparam int DEPTH = 2 ** MEM_AW;

    logic [MEM_AW-1:0] maddr;
    logic              store_fire;
    logic              load_fire;

    assign maddr      = ex_result[MEM_AW-1:0];
    assign store_fire = ex_valid & ex_mem_write & ~reset;
    // A simultaneous read+write request is treated as a plain store.
    assign load_fire  = ex_valid & ex_mem_read & ~ex_mem_write & ~reset;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ex_result[DATA_W-1:MEM_AW];

    // Data memory: the array carries no reset so it maps onto block RAM; a
    // per-word "written since reset" flag makes untouched words read as 0.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  live_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rdata_live_reg;

    always_ff @(posedge clk) begin
        if (store_fire) begin
            mem[maddr] <= ex_store_data;
        end
        if (load_fire) begin
            rdata_reg <= mem[maddr];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            always_ff @(posedge clk) begin
                if (reset) begin
                    live_reg[gi] <= 1'b0;
                end else if (store_fire && maddr == MEM_AW'(gi)) begin
                    live_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_live_reg <= 1'b0;
        end else if (load_fire) begin
            rdata_live_reg <= live_reg[maddr];
        end
    end

    // Pipeline register between the memory edge and the write-back cycle.
    logic              v_reg;
    logic              wb_reg;
    logic              is_load_reg;
    logic [REG_AW-1:0] dest_reg;
    logic [DATA_W-1:0] alu_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg       <= 1'b0;
            wb_reg      <= 1'b0;
            is_load_reg <= 1'b0;
            dest_reg    <= '0;
            alu_reg     <= '0;
        end else if (ex_valid) begin
            v_reg       <= 1'b1;
            wb_reg      <= ex_wb;
            is_load_reg <= ex_mem_read & ~ex_mem_write;
            dest_reg    <= ex_dest;
            alu_reg     <= ex_result;
        end else begin
            v_reg <= 1'b0;
        end
    end

    // Write-back port: live values while writing, last written values otherwise.
    logic              wen_next;
    logic [DATA_W-1:0] wdata_next;
    logic [REG_AW-1:0] hold_addr_reg;
    logic [DATA_W-1:0] hold_data_reg;

    always_comb begin
        wen_next   = v_reg & wb_reg;
        wdata_next = alu_reg;
        if (is_load_reg) begin
            wdata_next = rdata_live_reg ? rdata_reg : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
        end else if (wen_next) begin
            hold_addr_reg <= dest_reg;
            hold_data_reg <= wdata_next;
        end
    end

    assign write_en   = wen_next;
    assign write_addr = wen_next ? dest_reg : hold_addr_reg;
    assign write_data = wen_next ? wdata_next : hold_data_reg;
    assign fwd_valid  = write_en;
    assign fwd_addr   = write_addr;
    assign fwd_data   = write_data;

    // Status: sticky illegal flag and retired-instruction counter.
    logic        illegal_reg;
    logic [15:0] retired_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else if (ex_valid) begin
            retired_reg <= retired_reg + 16'd1;
            if (ex_mem_read && ex_mem_write) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    assign illegal_op    = illegal_reg;
    assign retired_count = retired_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios, random traffic and
// a long throughput run, all checked against a word-level behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [15:0] ex_result;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_dest;
    logic        ex_wb;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        write_en;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        illegal_op;
    logic [15:0] retired_count;

    mem_wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_wb         (ex_wb),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .illegal_op    (illegal_op),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit verbose  = 1'b1;

    // Reference model state: what the register file port and status should
    // show after each edge.
    logic [15:0] m_mem [256];
    logic        m_en;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic        m_ill;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [15:0] res,
                              input logic [15:0] sd, input logic [2:0] dest,
                              input logic wb, input logic rd, input logic wr);
        logic [7:0]  a;
        logic [15:0] val;
        a = res[7:0];
        if (rst) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
            m_en = 1'b0; m_addr = 3'd0; m_data = 16'h0; m_ill = 1'b0; m_cnt = 16'h0;
        end else if (v) begin
            val = (rd && !wr) ? m_mem[a] : res;
            if (wr) m_mem[a] = sd;
            if (rd && wr) m_ill = 1'b1;
            m_cnt = m_cnt + 16'd1;
            m_en  = wb;
            if (wb) begin
                m_addr = dest;
                m_data = val;
            end
        end else begin
            m_en = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, clock in, then check at the next
    // falling edge.
    task automatic cycle(input logic rst, input logic v, input logic [15:0] res,
                         input logic [15:0] sd, input logic [2:0] dest,
                         input logic wb, input logic rd, input logic wr);
        reset = rst; ex_valid = v; ex_result = res; ex_store_data = sd;
        ex_dest = dest; ex_wb = wb; ex_mem_read = rd; ex_mem_write = wr;
        model_step(rst, v, res, sd, dest, wb, rd, wr);
        @(posedge clk);
        @(negedge clk);
        check("write_en", write_en, m_en);
        check("write_addr", write_addr, m_addr);
        check("write_data", write_data, m_data);
        check("fwd_valid", fwd_valid, write_en);
        check("fwd_addr", fwd_addr, write_addr);
        check("fwd_data", fwd_data, write_data);
        check("illegal_op", illegal_op, m_ill);
        check("retired_count", retired_count, m_cnt);
        if (verbose)
            $display("txn rst=%b v=%b res=%h sd=%h d=%0d wb=%b rd=%b wr=%b -> en=%b a=%0d d=%h ill=%b cnt=%0d",
                     rst, v, res, sd, dest, wb, rd, wr, write_en, write_addr, write_data,
                     illegal_op, retired_count);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] r;
        logic        rr, ww;
        reset = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0;
        ex_dest = '0; ex_wb = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("rst_write_en", write_en, 1'b0);
        check("rst_count", retired_count, 16'h0);

        // ALU write-back
        cycle(1'b0, 1'b1, 16'h1234, 16'h0, 3'd5, 1'b1, 1'b0, 1'b0);
        check("alu_data", write_data, 16'h1234);
        check("alu_addr", write_addr, 3'd5);
        idle();
        check("alu_idle_en", write_en, 1'b0);
        check("alu_hold_data", write_data, 16'h1234);
        check("alu_count", retired_count, 16'd1);

        // Store then load, back to back
        cycle(1'b0, 1'b1, 16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h0010, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0);
        check("st_ld_data", write_data, 16'hBEEF);
        check("st_ld_addr", write_addr, 3'd2);

        // Load then store same address: load sees old value
        cycle(1'b0, 1'b1, 16'h0010, 16'h0, 3'd3, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 16'h0010, 16'h1111, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h0010, 16'h0, 3'd4, 1'b1, 1'b1, 1'b0);
        check("ld_after_st_new", write_data, 16'h1111);

        // Address wrap
        cycle(1'b0, 1'b1, 16'h0105, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h0005, 16'h0, 3'd6, 1'b1, 1'b1, 1'b0);
        check("wrap_data", write_data, 16'hA5A5);

        // Illegal op: store executes, ALU result written back, flag sticks
        cycle(1'b0, 1'b1, 16'h0003, 16'h7777, 3'd1, 1'b1, 1'b1, 1'b1);
        check("ill_data", write_data, 16'h0003);
        check("ill_flag", illegal_op, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        check("ill_sticky", illegal_op, 1'b1);
        cycle(1'b0, 1'b1, 16'h0003, 16'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        check("ill_mem3", write_data, 16'h7777);

        // Reset on the same edge as a valid load
        cycle(1'b1, 1'b1, 16'h0010, 16'h0, 3'd7, 1'b1, 1'b1, 1'b0);
        check("midrst_en", write_en, 1'b0);
        check("midrst_count", retired_count, 16'h0);
        check("midrst_ill", illegal_op, 1'b0);
        cycle(1'b0, 1'b1, 16'h0010, 16'h0, 3'd7, 1'b1, 1'b1, 1'b0);
        check("midrst_mem_cleared", write_data, 16'h0000);

        // Random traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 1) == 1) r[7:3] = 5'd0;
            rr = ($urandom_range(0, 2) == 0);
            ww = ($urandom_range(0, 2) == 0);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), r,
                  16'($urandom), 3'($urandom), 1'($urandom), rr, ww);
        end

        // Throughput and counter wrap
        cycle(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b0, 1'b1, 16'($urandom), 16'h0, 3'(i % 8), 1'b1, 1'b0, 1'b0);
        end
        check("tp_final_count", retired_count, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
